// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like address/data phase bundle shared by requesters and the slave port.
// master drives req/cmd; slave answers addr_ok/data_ok/rdata.
interface sram_bus_arbiter_if #(
    parameter int CMD_W = 71
);
    logic             req;
    logic [CMD_W-1:0] cmd;
    logic             addr_ok;
    logic             data_ok;
    logic [31:0]      rdata;

    modport master (
        output req, cmd,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, cmd,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-requester arbiter (inst/data) onto one SRAM-like port, in-order responses.
// Define ARB_RR_EN for round-robin arbitration; default is data-over-inst priority.
module sram_bus_arbiter #(
    parameter int OUTST_DEPTH = 4,
    parameter int CMD_W       = 71
) (
    input logic            clk,
    input logic            resetn,
    sram_bus_arbiter_if.slave  inst,
    sram_bus_arbiter_if.slave  data,
    sram_bus_arbiter_if.master s
);
    localparam int AW = $clog2(OUTST_DEPTH);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]             state;
    logic                   owner;
    logic [OUTST_DEPTH-1:0] fifo;
    logic [AW-1:0]          wp;
    logic [AW-1:0]          rp;
    logic [AW:0]            cnt;

    logic             lock_vld;
    logic             gnt_any;
    logic             gnt_data;
    logic             both_pick;
    logic             full;
    logic             xfer;
    logic             pop;
    logic             head;
    logic [CMD_W-1:0] gnt_cmd;

    // Lock only binds while its owner keeps requesting.
    assign lock_vld = (state == LOCKED) &
                      (owner ? data.req : inst.req);

`ifdef ARB_RR_EN
    logic prio;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio <= 1'b1;
        end else if (xfer) begin
            prio <= ~gnt_data;
        end
    end

    assign both_pick = prio;
`else
    assign both_pick = 1'b1;
`endif

    always_comb begin
        gnt_any  = 1'b0;
        gnt_data = 1'b0;
        if (lock_vld) begin
            gnt_any  = 1'b1;
            gnt_data = owner;
        end else if (data.req & inst.req) begin
            gnt_any  = 1'b1;
            gnt_data = both_pick;
        end else if (data.req) begin
            gnt_any  = 1'b1;
            gnt_data = 1'b1;
        end else if (inst.req) begin
            gnt_any  = 1'b1;
            gnt_data = 1'b0;
        end
    end

    always_comb begin
        gnt_cmd = '0;
        if (gnt_any) begin
            gnt_cmd = gnt_data ? data.cmd : inst.cmd;
        end
    end

    // full comes only from the count register, so s_data_ok never reaches s_req.
    assign full   = (cnt == (AW + 1)'(OUTST_DEPTH));
    assign s.req  = resetn & gnt_any & ~full;
    assign s.cmd  = gnt_cmd;
    assign xfer   = s.req & s.addr_ok;

    assign inst.addr_ok = xfer & ~gnt_data;
    assign data.addr_ok = xfer & gnt_data;

    assign head = fifo[rp];
    assign pop  = resetn & s.data_ok & (cnt != '0);

    assign inst.data_ok = pop & ~head;
    assign data.data_ok = pop & head;
    assign inst.rdata   = s.rdata;
    assign data.rdata   = s.rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            owner <= 1'b0;
        end else if (s.req & ~s.addr_ok) begin
            state <= LOCKED;
            owner <= gnt_data;
        end else if ((state == LOCKED) & (xfer | ~lock_vld)) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (xfer) begin
                fifo[wp] <= gnt_data;
                wp       <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            unique case ({xfer, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Scoreboard bench for sram_bus_arbiter: stimulus queues expected accepts and
// responses, a negedge monitor pops and compares them.
module tb_sram_bus_arbiter;
    localparam int CW = 71;
    localparam logic [70:0] ICMD =
        {1'b0, 2'd2, 4'hf, 32'h0000_1000, 32'h0};
    localparam logic [70:0] DCMD =
        {1'b1, 2'd2, 4'h3, 32'h8000_0040, 32'hdead_beef};

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic        acc_q[$];
    logic [32:0] rsp_q[$];

    sram_bus_arbiter_if #(.CMD_W(CW)) inst_if ();
    sram_bus_arbiter_if #(.CMD_W(CW)) data_if ();
    sram_bus_arbiter_if #(.CMD_W(CW)) s_if ();

    sram_bus_arbiter #(
        .OUTST_DEPTH(4),
        .CMD_W(CW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .inst(inst_if),
        .data(data_if),
        .s(s_if)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [70:0] act, logic [70:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(bit ir, bit dr, bit aok, bit dok, logic [31:0] rd);
        @(posedge clk);
        #1;
        inst_if.req  = ir;
        data_if.req  = dr;
        s_if.addr_ok = aok;
        s_if.data_ok = dok;
        s_if.rdata   = rd;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 32'h0);
    endtask

    // Monitor: every accept and every response must match the queues.
    always @(negedge clk) begin
        logic        e;
        logic [32:0] r;
        if (inst_if.addr_ok | data_if.addr_ok) begin
            checks++;
            if (inst_if.addr_ok & data_if.addr_ok) begin
                errors++;
                $display("FAIL accept: both addr_ok high at %0t", $time);
            end else if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL accept: unexpected data_addr_ok=%0b at %0t",
                         data_if.addr_ok, $time);
            end else begin
                e = acc_q.pop_front();
                if (data_if.addr_ok !== e) begin
                    errors++;
                    $display("FAIL accept owner: got data=%0b expected data=%0b at %0t",
                             data_if.addr_ok, e, $time);
                end
            end
        end
        if (inst_if.data_ok | data_if.data_ok) begin
            checks++;
            if (inst_if.data_ok & data_if.data_ok) begin
                errors++;
                $display("FAIL response: both data_ok high at %0t", $time);
            end else if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL response: unexpected data_data_ok=%0b at %0t",
                         data_if.data_ok, $time);
            end else begin
                r = rsp_q.pop_front();
                if (data_if.data_ok !== r[32] ||
                    (data_if.data_ok ? data_if.rdata : inst_if.rdata) !== r[31:0]) begin
                    errors++;
                    $display("FAIL response: got data=%0b rdata=%h expected data=%0b rdata=%h",
                             data_if.data_ok,
                             data_if.data_ok ? data_if.rdata : inst_if.rdata,
                             r[32], r[31:0]);
                end
            end
        end
    end

    initial begin
        inst_if.req  = 1'b0;
        inst_if.cmd  = ICMD;
        data_if.req  = 1'b0;
        data_if.cmd  = DCMD;
        s_if.addr_ok = 1'b0;
        s_if.data_ok = 1'b0;
        s_if.rdata   = 32'h0;

        // Reset with everything asserted: outputs must stay quiet.
        drv(1, 1, 1, 1, 32'hbad0);
        @(negedge clk);
        chk("rst s_req", 71'(s_if.req), 71'd0);
        chk("rst addr_ok", 71'({inst_if.addr_ok, data_if.addr_ok}), 71'd0);
        chk("rst data_ok", 71'({inst_if.data_ok, data_if.data_ok}), 71'd0);
        idle();
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // 1: both request with slave ready for two cycles.
        drv(1, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        @(negedge clk);
        chk("t1 c0 s_cmd", s_if.cmd, DCMD);
        drv(1, 1, 1, 0, 32'h0);
`ifdef ARB_RR_EN
        acc_q.push_back(1'b0);
        rsp_q.push_back({1'b1, 32'h0000_00a1});
        rsp_q.push_back({1'b0, 32'h0000_00a2});
        @(negedge clk);
        chk("t1 c1 s_cmd", s_if.cmd, ICMD);
`else
        acc_q.push_back(1'b1);
        rsp_q.push_back({1'b1, 32'h0000_00a1});
        rsp_q.push_back({1'b1, 32'h0000_00a2});
        @(negedge clk);
        chk("t1 c1 s_cmd", s_if.cmd, DCMD);
`endif
        drv(0, 0, 0, 1, 32'h0000_00a1);
        drv(0, 0, 0, 1, 32'h0000_00a2);
        idle();
        @(negedge clk);
        chk("idle s_cmd", s_if.cmd, 71'd0);

        // 2: inst locked while slave stalls; data waits until release.
        drv(1, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("t2 c0 s_cmd", s_if.cmd, ICMD);
        for (int c = 1; c < 3; c++) begin
            drv(1, 1, 0, 0, 32'h0);
            @(negedge clk);
            chk($sformatf("t2 c%0d lock s_cmd", c), s_if.cmd, ICMD);
        end
        drv(1, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b0);
        @(negedge clk);
        chk("t2 c3 s_cmd", s_if.cmd, ICMD);
        drv(1, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        @(negedge clk);
        chk("t2 c4 s_cmd", s_if.cmd, DCMD);
        rsp_q.push_back({1'b0, 32'h0000_0005});
        rsp_q.push_back({1'b1, 32'h0000_0006});
        drv(0, 0, 0, 1, 32'h0000_0005);
        drv(0, 0, 0, 1, 32'h0000_0006);
        idle();

        // 3: fill to depth, stall, pop one, resume a cycle later.
        for (int i = 0; i < 4; i++) begin
            drv(0, 1, 1, 0, 32'h0);
            acc_q.push_back(1'b1);
        end
        drv(0, 1, 1, 0, 32'h0);
        @(negedge clk);
        chk("t3 full s_req", 71'(s_if.req), 71'd0);
        drv(0, 1, 1, 1, 32'h0000_0031);
        rsp_q.push_back({1'b1, 32'h0000_0031});
        @(negedge clk);
        chk("t3 pop s_req", 71'(s_if.req), 71'd0);
        drv(0, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        @(negedge clk);
        chk("t3 resume s_req", 71'(s_if.req), 71'd1);
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 1, 32'h0000_0032 + 32'(i));
            rsp_q.push_back({1'b1, 32'h0000_0032 + 32'(i)});
        end
        idle();

        // 4: data, inst, data accepted, responses routed in order.
        drv(0, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        drv(1, 0, 1, 0, 32'h0);
        acc_q.push_back(1'b0);
        drv(0, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        rsp_q.push_back({1'b1, 32'h0000_0011});
        rsp_q.push_back({1'b0, 32'h0000_0022});
        rsp_q.push_back({1'b1, 32'h0000_0033});
        drv(0, 0, 0, 1, 32'h0000_0011);
        drv(0, 0, 0, 1, 32'h0000_0022);
        drv(0, 0, 0, 1, 32'h0000_0033);
        idle();

        // 5: reset discards two outstanding; stray response is dropped.
        drv(1, 0, 1, 0, 32'h0);
        acc_q.push_back(1'b0);
        drv(0, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        drv(1, 1, 1, 0, 32'h0);
        resetn = 1'b0;
        @(negedge clk);
        chk("t5 rst s_req", 71'(s_if.req), 71'd0);
        chk("t5 rst addr_ok", 71'({inst_if.addr_ok, data_if.addr_ok}), 71'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        inst_if.req  = 1'b0;
        data_if.req  = 1'b0;
        s_if.addr_ok = 1'b0;
        s_if.data_ok = 1'b1;
        s_if.rdata   = 32'h0000_0055;
        @(negedge clk);
        chk("t5 stray data_ok", 71'({inst_if.data_ok, data_if.data_ok}), 71'd0);
        idle();

        // 6: push and pop together at count 2 keep order.
        drv(1, 0, 1, 0, 32'h0);
        acc_q.push_back(1'b0);
        drv(0, 1, 1, 0, 32'h0);
        acc_q.push_back(1'b1);
        drv(0, 1, 1, 1, 32'h0000_0061);
        acc_q.push_back(1'b1);
        rsp_q.push_back({1'b0, 32'h0000_0061});
        rsp_q.push_back({1'b1, 32'h0000_0062});
        rsp_q.push_back({1'b1, 32'h0000_0063});
        drv(0, 0, 0, 1, 32'h0000_0062);
        drv(0, 0, 0, 1, 32'h0000_0063);
        drv(0, 0, 0, 1, 32'h0000_0064);
        @(negedge clk);
        chk("t6 empty data_ok", 71'({inst_if.data_ok, data_if.data_ok}), 71'd0);
        idle();
        idle();

        chk("acc_q drained", 71'(acc_q.size()), 71'd0);
        chk("rsp_q drained", 71'(rsp_q.size()), 71'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
